map_server: RTL and testbench
=============================

// Module: map_server
// PURPOSE
//  Game-field wall map and responder for the VGA renderer's tile-request interface: answers (x,y)
//  requests with a registered is_wall bit. Holds a WIDTH x GAME_HEIGHT bitmap (64x44) in flops.
//  Buffers game-logic wall updates in a small FIFO and commits them only while the renderer is not busy
//  (vertical blanking), so no frame shows a half-updated map. Also serves a second read port for collision checks.
// PARAMETERS
//  WIDTH        64  map columns (x range 0..63)
//  GAME_HEIGHT  44  map rows (y range 0..43); rows >= 44 are out of range
//  FIFO_DEPTH   8   pending-write buffer entries (power of 2)
// PORTS
//  clk            in   1  system clock (same clock as VGA)
//  rst            in   1  synchronous, active-high reset
//  i_buzy         in   1  renderer active-area flag; 1 = no map commits allowed
//  i_request_x    in   6  renderer tile x
//  i_request_y    in   6  renderer tile y (game-area row)
//  o_is_wall      out  1  wall bit for the previous cycle's request
//  i_query_x      in   6  game-logic collision query x
//  i_query_y      in   6  game-logic collision query y
//  o_query_wall   out  1  wall bit for the previous cycle's query
//  i_init         in   1  pulse: rebuild default layout
//  o_ready        out  1  1 when map initialised (state IDLE)
//  i_wr_valid     in   1  write request valid
//  o_wr_ready     out  1  write request accepted when valid&ready
//  i_wr_x         in   6  write x
//  i_wr_y         in   6  write y
//  i_wr_wall      in   1  value to store (1 = wall, 0 = destroyed)
// BEHAVIOUR
//  - Reset: o_is_wall=0, o_query_wall=0, o_ready=0, o_wr_ready=0, FIFO empty, state=CLEAR, row=0.
//  - FSM CLEAR: writes one whole row per cycle, row 0..43; cell=1 if x==0|x==63|y==0|y==43 else 0.
//    After row 43: -> IDLE. CLEAR therefore lasts exactly 44 cycles after rst release.
//  - FSM IDLE: o_ready=1. If i_init: FIFO flushed, row=0, -> CLEAR. i_init in CLEAR restarts at row 0.
//  - Reads: both ports 1-cycle latency, registered; active in every state (return partial map in CLEAR).
//    y >= GAME_HEIGHT reads as 1 (wall). Read-before-write: same-cycle commit to read cell returns old value.
//  - Writes: o_wr_ready = (state==IDLE) & ~full & ~i_init. Accepted entry pushed into FIFO.
//    Commit: in IDLE, when ~i_buzy & ~empty, pop one entry per cycle, write bitmap next edge.
//    Entries with y >= GAME_HEIGHT are popped and dropped. Later entries to same cell win (FIFO order).
//  - Simultaneous push & pop: occupancy unchanged; push while full is not accepted (ready=0).
//  - i_buzy rising mid-drain: stop popping that cycle; remaining entries wait for next blanking.
//  - Occupancy counter width $clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
// CONFIGURATION
//  MAP_SERVER_PILLARS_EN defined: CLEAR also sets interior cells with x[2:0]==4 && y[2:0]==4 to 1.
//  Undefined: interior of default layout all 0 (border only). No other behaviour changes.
// STRUCTURE
//  map_pkg: WIDTH, GAME_HEIGHT constants; state enum {CLEAR, IDLE}; struct wr_req_t {x[5:0], y[5:0], wall}.
//  Sub-module map_wr_fifo (parameter DEPTH, payload wr_req_t; push/pop/full/empty, sync flush).
//  Top holds bitmap, FSM, row counter, two registered read muxes.
// TESTING
//  1 rst 1->0; count cycles -> o_ready rises 44 cycles later; req (0,5) -> o_is_wall=1 next cycle; (10,10) -> 0.
//  2 i_buzy=1, write (10,10,1) accepted -> query (10,10)=0 while busy; i_buzy=0 -> 1 two cycles later.
//  3 i_buzy=1, push 8 writes -> o_wr_ready=0 on 9th; i_buzy=0 -> 8 commits in 8 cycles, then ready=1.
//  4 req (3,50) -> o_is_wall=1; write (3,50,0) accepted, dropped on pop; map otherwise unchanged.
//  5 FIFO holds 3 entries, (20,20) already 1, pulse i_init -> FIFO empty, o_ready=0 44 cycles, (20,20)=0.
//  6 MAP_SERVER_PILLARS_EN: (4,4)=1, (12,4)=1, (5,4)=0; without macro (4,4)=0, (0,4)=1.

Source files
------------

// File: rtl/map_pkg.sv
// Shared constants and types for the wall-map server.
// Holds map geometry, the init/idle state encoding, the queued write
// request layout and the default-layout cell rule.
package map_pkg;

    localparam int WIDTH       = 64;
    localparam int GAME_HEIGHT = 44;
    localparam int FIFO_DEPTH  = 8;

    localparam logic [5:0] LAST_COL  = 6'(WIDTH - 1);
    localparam logic [5:0] LAST_ROW  = 6'(GAME_HEIGHT - 1);
    localparam logic [5:0] ROW_LIMIT = 6'(GAME_HEIGHT);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    typedef struct packed {
        logic [5:0] x;
        logic [5:0] y;
        logic       wall;
    } wr_req_t;

    // Default layout: solid border, optional pillar grid in the interior.
    function automatic logic default_cell(input logic [5:0] x, input logic [5:0] y,
                                          input logic pillars);
        logic border;
        logic pillar;
        border = (x == 6'd0) || (x == LAST_COL) || (y == 6'd0) || (y == LAST_ROW);
        pillar = pillars && (x[2:0] == 3'd4) && (y[2:0] == 3'd4);
        return border || pillar;
    endfunction

endpackage

// File: rtl/map_wr_fifo.sv
// Small FIFO of pending wall writes. Head entry is visible combinationally
// so the consumer can commit it on the same edge that pops it.
// Synchronous flush discards all entries.
module map_wr_fifo
    import map_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    flush,
    input  logic    push,
    input  wr_req_t push_data,
    input  logic    pop,
    output wr_req_t head,
    output logic    full,
    output logic    empty
);

    localparam int PTR_W = $clog2(DEPTH);

    wr_req_t            mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W:0]     count_reg;
    logic               push_ok;
    logic               pop_ok;

    assign full    = (count_reg == (PTR_W + 1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign push_ok = push & ~full & ~flush;
    assign pop_ok  = pop & ~empty & ~flush;
    assign head    = mem[rd_ptr_reg];

    // Entry storage; written at the tail on an accepted push.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally (power-of-two depth); count tracks occupancy.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/map_server.sv
// Wall-map server: 64x44 wall bitmap with two registered read ports
// (renderer and collision query), a row-per-cycle rebuild of the default
// layout, and a write FIFO drained only while the renderer is idle.
// Build option: MAP_SERVER_PILLARS_EN adds a pillar grid to the default layout.
module map_server
    import map_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_buzy,
    input  logic [5:0] i_request_x,
    input  logic [5:0] i_request_y,
    output logic       o_is_wall,
    input  logic [5:0] i_query_x,
    input  logic [5:0] i_query_y,
    output logic       o_query_wall,
    input  logic       i_init,
    output logic       o_ready,
    input  logic       i_wr_valid,
    output logic       o_wr_ready,
    input  logic [5:0] i_wr_x,
    input  logic [5:0] i_wr_y,
    input  logic       i_wr_wall
);

`ifdef MAP_SERVER_PILLARS_EN
    localparam logic PILLARS = 1'b1;
`else
    localparam logic PILLARS = 1'b0;
`endif

    state_t             state_reg, state_next;
    logic [5:0]         row_reg, row_next;
    logic [WIDTH-1:0]   map_reg [GAME_HEIGHT];
    logic [WIDTH-1:0]   clear_row;
    logic               is_wall_reg;
    logic               query_wall_reg;
    logic               fifo_full, fifo_empty;
    logic               push, pop, commit, clear_wr;
    wr_req_t            push_data, head;

    assign o_ready    = (state_reg == IDLE);
    assign o_wr_ready = (state_reg == IDLE) & ~fifo_full & ~i_init;
    assign push       = i_wr_valid & o_wr_ready;
    assign pop        = (state_reg == IDLE) & ~i_buzy & ~fifo_empty & ~i_init;
    assign commit     = pop & (head.y < ROW_LIMIT);
    assign clear_wr   = (state_reg == CLEAR) & ~i_init;
    assign push_data  = '{x: i_wr_x, y: i_wr_y, wall: i_wr_wall};

    map_wr_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (i_init),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Default-layout contents of the row currently being rebuilt.
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_clear_col
        assign clear_row[gi] = default_cell(6'(gi), row_reg, PILLARS);
    end

    // State and rebuild-row registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= CLEAR;
            row_reg   <= '0;
        end else begin
            state_reg <= state_next;
            row_reg   <= row_next;
        end
    end

    // Next state: walk rows 0..43 in CLEAR, init restarts from row 0.
    always_comb begin
        state_next = state_reg;
        row_next   = row_reg;
        case (state_reg)
            CLEAR: begin
                if (i_init) begin
                    row_next = '0;
                end else if (row_reg == LAST_ROW) begin
                    state_next = IDLE;
                    row_next   = '0;
                end else begin
                    row_next = row_reg + 1'b1;
                end
            end
            IDLE: begin
                if (i_init) begin
                    state_next = CLEAR;
                    row_next   = '0;
                end
            end
            default: begin
                state_next = CLEAR;
                row_next   = '0;
            end
        endcase
    end

    // Bitmap update: whole row during rebuild, single cell on a commit.
    always_ff @(posedge clk) begin
        if (clear_wr) begin
            map_reg[row_reg] <= clear_row;
        end else if (commit) begin
            map_reg[head.y][head.x] <= head.wall;
        end
    end

    // Registered read ports; rows past the game area read as wall.
    always_ff @(posedge clk) begin
        if (rst) begin
            is_wall_reg    <= 1'b0;
            query_wall_reg <= 1'b0;
        end else begin
            is_wall_reg    <= (i_request_y >= ROW_LIMIT) ? 1'b1
                                                         : map_reg[i_request_y][i_request_x];
            query_wall_reg <= (i_query_y >= ROW_LIMIT) ? 1'b1
                                                       : map_reg[i_query_y][i_query_x];
        end
    end

    assign o_is_wall    = is_wall_reg;
    assign o_query_wall = query_wall_reg;

endmodule

// File: tb/tb_map_server.sv
// Self-checking bench for map_server: directed scenarios plus a randomized
// run, all compared against a queue/array model of the wall map.
module tb_map_server;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_buzy;
    logic [5:0] i_request_x, i_request_y;
    logic       o_is_wall;
    logic [5:0] i_query_x, i_query_y;
    logic       o_query_wall;
    logic       i_init;
    logic       o_ready;
    logic       i_wr_valid;
    logic       o_wr_ready;
    logic [5:0] i_wr_x, i_wr_y;
    logic       i_wr_wall;

    int errors = 0;
    int checks = 0;

`ifdef MAP_SERVER_PILLARS_EN
    localparam bit PILL = 1'b1;
`else
    localparam bit PILL = 1'b0;
`endif

    map_server dut (
        .clk          (clk),
        .rst          (rst),
        .i_buzy       (i_buzy),
        .i_request_x  (i_request_x),
        .i_request_y  (i_request_y),
        .o_is_wall    (o_is_wall),
        .i_query_x    (i_query_x),
        .i_query_y    (i_query_y),
        .o_query_wall (o_query_wall),
        .i_init       (i_init),
        .o_ready      (o_ready),
        .i_wr_valid   (i_wr_valid),
        .o_wr_ready   (o_wr_ready),
        .i_wr_x       (i_wr_x),
        .i_wr_y       (i_wr_y),
        .i_wr_wall    (i_wr_wall)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct {
        logic [5:0] x;
        logic [5:0] y;
        logic       wall;
    } ent_t;

    bit   mdl_map [44][64];
    ent_t mdl_q [$];
    int   clear_left;
    bit   exp_valid;
    bit   exp_is_wall;
    bit   exp_query;

    function automatic bit dflt(int x, int y);
        return (x == 0) || (x == 63) || (y == 0) || (y == 43) ||
               (PILL && (x % 8 == 4) && (y % 8 == 4));
    endfunction

    function automatic bit mdl_read(logic [5:0] x, logic [5:0] y);
        if (y >= 44) return 1'b1;
        return mdl_map[y][x];
    endfunction

    function automatic bit mdl_ready();
        return clear_left == 0;
    endfunction

    function automatic bit mdl_wr_ready();
        return (clear_left == 0) && (mdl_q.size() < 8) && !i_init;
    endfunction

    task automatic load_default();
        for (int y = 0; y < 44; y++)
            for (int x = 0; x < 64; x++)
                mdl_map[y][x] = dflt(x, y);
    endtask

    // Advance the model by one clock with the current inputs, then clock the DUT.
    task automatic step();
        ent_t e;
        bit   acc;
        if (rst) begin
            mdl_q.delete();
            clear_left  = 44;
            exp_valid   = 1'b1;
            exp_is_wall = 1'b0;
            exp_query   = 1'b0;
        end else begin
            exp_valid   = (clear_left == 0);
            exp_is_wall = mdl_read(i_request_x, i_request_y);
            exp_query   = mdl_read(i_query_x, i_query_y);
            if (i_init) begin
                mdl_q.delete();
                clear_left = 44;
            end else if (clear_left > 0) begin
                clear_left--;
                if (clear_left == 0) load_default();
            end else begin
                acc = i_wr_valid && (mdl_q.size() < 8);
                if (!i_buzy && mdl_q.size() > 0) begin
                    e = mdl_q.pop_front();
                    if (e.y < 44) mdl_map[e.y][e.x] = e.wall;
                end
                if (acc) begin
                    e.x = i_wr_x; e.y = i_wr_y; e.wall = i_wr_wall;
                    mdl_q.push_back(e);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        int cnt;
        rst = 1'b1;
        step(); step(); step();
        checks++;
        if (o_is_wall !== 1'b0 || o_query_wall !== 1'b0) begin
            errors++;
            $display("FAIL reset_reads: got is_wall=%0b query=%0b expected 0 0", o_is_wall, o_query_wall);
        end
        checks++;
        if (o_ready !== 1'b0 || o_wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got ready=%0b wr_ready=%0b expected 0 0", o_ready, o_wr_ready);
        end
        rst = 1'b0;
        #1;
        cnt = 0;
        while (o_ready !== 1'b1 && cnt < 100) begin
            step();
            cnt++;
        end
        checks++;
        if (cnt != 44) begin
            errors++;
            $display("FAIL clear_length: got %0d cycles expected 44", cnt);
        end
        $display("reset: ready after %0d cycles", cnt);
        i_request_x = 6'd0; i_request_y = 6'd5;
        step();
        checks++;
        if (o_is_wall !== 1'b1) begin
            errors++;
            $display("FAIL req_border_0_5: got %0b expected 1", o_is_wall);
        end
        i_request_x = 6'd10; i_request_y = 6'd10;
        step();
        checks++;
        if (o_is_wall !== exp_is_wall || exp_is_wall !== 1'b0) begin
            errors++;
            $display("FAIL req_interior_10_10: got %0b expected 0", o_is_wall);
        end
    endtask

    task automatic test_commit_blanking();
        i_buzy = 1'b1;
        i_wr_x = 6'd10; i_wr_y = 6'd10; i_wr_wall = 1'b1; i_wr_valid = 1'b1;
        #1;
        checks++;
        if (o_wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL commit_accept: got wr_ready=%0b expected 1", o_wr_ready);
        end
        step();
        i_wr_valid = 1'b0;
        i_query_x = 6'd10; i_query_y = 6'd10;
        step(); step();
        checks++;
        if (o_query_wall !== 1'b0) begin
            errors++;
            $display("FAIL commit_held_busy: got %0b expected 0", o_query_wall);
        end
        i_buzy = 1'b0;
        step();
        checks++;
        if (o_query_wall !== 1'b0) begin
            errors++;
            $display("FAIL commit_read_before_write: got %0b expected 0", o_query_wall);
        end
        step();
        checks++;
        if (o_query_wall !== 1'b1) begin
            errors++;
            $display("FAIL commit_visible: got %0b expected 1", o_query_wall);
        end
        $display("commit: (10,10) wall after blanking = %0b", o_query_wall);
    endtask

    task automatic test_fifo_full();
        logic [5:0] wx [8];
        logic [5:0] wy [8];
        i_buzy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wx[i] = 6'($urandom_range(61, 2));
            wy[i] = 6'($urandom_range(41, 2));
            i_wr_x = wx[i]; i_wr_y = wy[i]; i_wr_wall = 1'($urandom_range(1, 0));
            i_wr_valid = 1'b1;
            #1;
            checks++;
            if (o_wr_ready !== 1'b1) begin
                errors++;
                $display("FAIL fifo_push_%0d: got wr_ready=%0b expected 1", i, o_wr_ready);
            end
            step();
            $display("fifo: push (%0d,%0d,%0b)", wx[i], wy[i], i_wr_wall);
        end
        i_wr_x = 6'd20; i_wr_y = 6'd21; i_wr_wall = 1'b1;
        #1;
        checks++;
        if (o_wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL fifo_full_ready: got %0b expected 0", o_wr_ready);
        end
        step();
        i_wr_valid = 1'b0;
        i_buzy = 1'b0;
        for (int i = 0; i < 8; i++) step();
        checks++;
        if (o_wr_ready !== 1'b1 || mdl_q.size() != 0) begin
            errors++;
            $display("FAIL fifo_drained: got wr_ready=%0b expected 1", o_wr_ready);
        end
        i_buzy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            i_query_x = wx[i]; i_query_y = wy[i];
            i_request_x = wx[i]; i_request_y = wy[i];
            step();
            checks++;
            if (o_query_wall !== exp_query || o_is_wall !== exp_is_wall) begin
                errors++;
                $display("FAIL fifo_readback_%0d: got q=%0b r=%0b expected %0b", i,
                         o_query_wall, o_is_wall, exp_query);
            end
        end
        i_buzy = 1'b0;
    endtask

    task automatic test_out_of_range();
        int bad;
        i_request_x = 6'd3; i_request_y = 6'd50;
        step();
        checks++;
        if (o_is_wall !== 1'b1) begin
            errors++;
            $display("FAIL oor_read: got %0b expected 1", o_is_wall);
        end
        i_wr_x = 6'd3; i_wr_y = 6'd50; i_wr_wall = 1'b0; i_wr_valid = 1'b1;
        #1;
        checks++;
        if (o_wr_ready !== 1'b1) begin
            errors++;
            $display("FAIL oor_accept: got %0b expected 1", o_wr_ready);
        end
        step();
        i_wr_valid = 1'b0;
        step(); step();
        checks++;
        if (o_is_wall !== 1'b1) begin
            errors++;
            $display("FAIL oor_after_drop: got %0b expected 1", o_is_wall);
        end
        bad = 0;
        for (int y = 0; y < 64; y++) begin
            for (int x = 0; x < 64; x += 2) begin
                i_request_x = 6'(x); i_request_y = 6'(y);
                i_query_x = 6'(x + 1); i_query_y = 6'(y);
                step();
                checks++;
                if (o_is_wall !== exp_is_wall || o_query_wall !== exp_query) begin
                    errors++;
                    bad++;
                    if (bad < 10)
                        $display("FAIL sweep_%0d_%0d: got r=%0b q=%0b expected r=%0b q=%0b",
                                 x, y, o_is_wall, o_query_wall, exp_is_wall, exp_query);
                end
            end
        end
        $display("out_of_range: full sweep mismatches=%0d", bad);
    endtask

    task automatic test_init();
        int bad;
        i_wr_x = 6'd20; i_wr_y = 6'd20; i_wr_wall = 1'b1; i_wr_valid = 1'b1;
        step();
        i_wr_valid = 1'b0;
        i_query_x = 6'd20; i_query_y = 6'd20;
        step(); step();
        checks++;
        if (o_query_wall !== 1'b1) begin
            errors++;
            $display("FAIL init_pre_wall: got %0b expected 1", o_query_wall);
        end
        i_buzy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            i_wr_x = 6'(30 + i); i_wr_y = 6'(30 + i); i_wr_wall = 1'b1; i_wr_valid = 1'b1;
            step();
        end
        i_wr_valid = 1'b0;
        i_init = 1'b1;
        #1;
        checks++;
        if (o_wr_ready !== 1'b0) begin
            errors++;
            $display("FAIL init_blocks_write: got %0b expected 0", o_wr_ready);
        end
        step();
        i_init = 1'b0;
        bad = 0;
        for (int i = 0; i < 44; i++) begin
            checks++;
            if (o_ready !== 1'b0) begin
                errors++;
                bad++;
                $display("FAIL init_not_ready_%0d: got %0b expected 0", i, o_ready);
            end
            step();
        end
        checks++;
        if (o_ready !== 1'b1) begin
            errors++;
            $display("FAIL init_ready_again: got %0b expected 1", o_ready);
        end
        i_buzy = 1'b0;
        step(); step(); step();
        i_query_x = 6'd20; i_query_y = 6'd20;
        i_request_x = 6'd30; i_request_y = 6'd30;
        step();
        checks++;
        if (o_query_wall !== 1'b0 || o_is_wall !== 1'b0) begin
            errors++;
            $display("FAIL init_cleared: got (20,20)=%0b (30,30)=%0b expected 0 0",
                     o_query_wall, o_is_wall);
        end
        $display("init: rebuilt, early-ready cycles=%0d", bad);
    endtask

    task automatic test_pillars();
        bit p44, p124, p54, p04;
        i_query_x = 6'd4;  i_query_y = 6'd4;  i_request_x = 6'd12; i_request_y = 6'd4;
        step(); p44 = o_query_wall; p124 = o_is_wall;
        i_query_x = 6'd5;  i_query_y = 6'd4;  i_request_x = 6'd0;  i_request_y = 6'd4;
        step(); p54 = o_query_wall; p04 = o_is_wall;
        checks++;
        if (p44 !== PILL || p124 !== PILL) begin
            errors++;
            $display("FAIL pillar_cells: got (4,4)=%0b (12,4)=%0b expected %0b", p44, p124, PILL);
        end
        checks++;
        if (p54 !== 1'b0 || p04 !== 1'b1) begin
            errors++;
            $display("FAIL pillar_neighbours: got (5,4)=%0b (0,4)=%0b expected 0 1", p54, p04);
        end
        $display("pillars: (4,4)=%0b (12,4)=%0b (5,4)=%0b (0,4)=%0b", p44, p124, p54, p04);
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int n = 0; n < 600; n++) begin
            i_buzy      = ($urandom_range(99, 0) < 50);
            i_init      = ($urandom_range(299, 0) == 0);
            i_wr_valid  = ($urandom_range(99, 0) < 60);
            i_wr_x      = 6'($urandom_range(7, 0));
            i_wr_y      = ($urandom_range(9, 0) == 0) ? 6'($urandom_range(63, 44))
                                                      : 6'($urandom_range(7, 0));
            i_wr_wall   = 1'($urandom_range(1, 0));
            i_request_x = 6'($urandom_range(7, 0));
            i_request_y = ($urandom_range(15, 0) == 0) ? 6'($urandom_range(63, 0))
                                                       : 6'($urandom_range(7, 0));
            i_query_x   = 6'($urandom_range(7, 0));
            i_query_y   = 6'($urandom_range(7, 0));
            #1;
            checks++;
            if (o_ready !== mdl_ready() || o_wr_ready !== mdl_wr_ready()) begin
                errors++;
                bad++;
                $display("FAIL rand_ready_%0d: got ready=%0b wr_ready=%0b expected %0b %0b",
                         n, o_ready, o_wr_ready, mdl_ready(), mdl_wr_ready());
            end
            step();
            if (exp_valid) begin
                checks++;
                if (o_is_wall !== exp_is_wall || o_query_wall !== exp_query) begin
                    errors++;
                    bad++;
                    $display("FAIL rand_read_%0d: got r=%0b q=%0b expected r=%0b q=%0b",
                             n, o_is_wall, o_query_wall, exp_is_wall, exp_query);
                end
            end
        end
        i_init = 1'b0; i_wr_valid = 1'b0; i_buzy = 1'b0;
        $display("random: 600 cycles, mismatches=%0d", bad);
    endtask

    initial begin
        rst = 1'b1; i_buzy = 1'b0; i_init = 1'b0; i_wr_valid = 1'b0;
        i_request_x = '0; i_request_y = '0; i_query_x = '0; i_query_y = '0;
        i_wr_x = '0; i_wr_y = '0; i_wr_wall = 1'b0;
        clear_left = 44;
        test_reset();
        test_commit_blanking();
        test_fifo_full();
        test_out_of_range();
        test_init();
        test_pillars();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
